// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the push-button debouncer:
//   CNT_W        width of every debounce / hold counter
//   key_state_e  per-key debounce FSM state encoding (2-bit)
//   ms_to_cyc    converts a millisecond duration into clock cycles
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // The frequency is divided down to cycles-per-millisecond first so the
  // product stays inside 32 bits for any realistic clock and duration.
  function automatic logic [CNT_W-1:0] ms_to_cyc(input logic [CNT_W-1:0] clk_freq,
                                                 input logic [CNT_W-1:0] ms);
    return (clk_freq / CNT_W'(1000)) * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// One push-button channel: 2-flop synchroniser, debounce FSM, debounce
// counter and long-press hold counter.
// Ports:
//   CLK_i      system clock
//   RST_i      asynchronous active-high reset
//   key_i      raw key pin, 0 = pressed, asynchronous to CLK_i
//   state_o    debounced level, 1 = pressed (registered)
//   press_o    1-cycle pulse on accepted press
//   release_o  1-cycle pulse on accepted release
//   long_o     1-cycle pulse once per press after the long-press hold time
// ---------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter logic [CNT_W-1:0] DB_CYC   = CNT_W'(20),
  parameter logic [CNT_W-1:0] LONG_CYC = CNT_W'(100)
) (
  input  logic CLK_i,
  input  logic RST_i,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0] DB_LAST   = DB_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYC - CNT_W'(1);

  logic [1:0]       sync_q;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] hold_inc;
  logic             long_done_q, long_done_d;
  logic             state_out_q, state_out_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  // Two-flop synchroniser on the raw pin. The flops hold the raw (active-low)
  // level, so their reset value of 1 means "released"; key_s is the
  // active-high pressed level that the FSM works on.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign key_s = ~sync_q[1];

  // Debounce FSM next-state logic. The hold counter runs in both held states
  // so a release bounce neither restarts nor pauses the long-press timing.
  // The long pulse is raised on the edge that brings the hold counter to
  // LONG_CYC-1, so it is visible while the counter holds that value.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    hold_inc    = (hold_cnt_q == LONG_CYC) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (key_s) begin
          state_d  = ST_PRESS_WAIT;
          db_cnt_d = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!key_s) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_PRESSED;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end

      ST_PRESSED: begin
        hold_cnt_d = hold_inc;
        if ((hold_inc == LONG_LAST) && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (!key_s) begin
          state_d  = ST_RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end

      ST_RELEASE_WAIT: begin
        hold_cnt_d = hold_inc;
        if ((hold_inc == LONG_LAST) && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (key_s) begin
          state_d = ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    state_out_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  // State, counters and registered outputs. Everything clears on reset, so a
  // reset in the middle of a press simply drops the outputs without a release.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      state_out_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      state_out_q <= state_out_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign state_o   = state_out_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Debounces KEY_NUM active-low push-buttons into clean per-key level and
// event outputs. Each key is handled by its own independent channel.
// Ports:
//   CLK_i          system clock
//   RST_i          asynchronous active-high reset
//   KEY_i          raw key pins, 0 = pressed
//   KEY_state_o    debounced level per key, 1 = pressed
//   KEY_press_o    1-cycle pulse per key on accepted press
//   KEY_release_o  1-cycle pulse per key on accepted release
//   KEY_long_o     1-cycle pulse per key once per long press
// ---------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 300_000_000,
  parameter int unsigned KEY_NUM       = 4,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic               CLK_i,
  input  logic               RST_i,
  input  logic [KEY_NUM-1:0] KEY_i,
  output logic [KEY_NUM-1:0] KEY_state_o,
  output logic [KEY_NUM-1:0] KEY_press_o,
  output logic [KEY_NUM-1:0] KEY_release_o,
  output logic [KEY_NUM-1:0] KEY_long_o
);

  localparam logic [CNT_W-1:0] DB_CYC   = ms_to_cyc(CNT_W'(CLK_FREQ), CNT_W'(DEBOUNCE_MS));
  localparam logic [CNT_W-1:0] LONG_CYC = ms_to_cyc(CNT_W'(CLK_FREQ), CNT_W'(LONG_PRESS_MS));

  // One fully independent channel per key; no state is shared between keys.
  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_debounce_ch #(
      .DB_CYC  (DB_CYC),
      .LONG_CYC(LONG_CYC)
    ) u_ch (
      .CLK_i    (CLK_i),
      .RST_i    (RST_i),
      .key_i    (KEY_i[g]),
      .state_o  (KEY_state_o[g]),
      .press_o  (KEY_press_o[g]),
      .release_o(KEY_release_o[g]),
      .long_o   (KEY_long_o[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
// Directed bench for key_debounce with a 10 kHz clock, 2 ms debounce
// (20 cycles) and 10 ms long press (100 cycles), four keys.
// ---------------------------------------------------------------------------
module tb_key_debounce;

  localparam int KEY_NUM = 4;

  logic               CLK_i;
  logic               RST_i;
  logic [KEY_NUM-1:0] KEY_i;
  logic [KEY_NUM-1:0] KEY_state_o;
  logic [KEY_NUM-1:0] KEY_press_o;
  logic [KEY_NUM-1:0] KEY_release_o;
  logic [KEY_NUM-1:0] KEY_long_o;

  int errCnt;
  int checkCnt;
  int cyc;
  int bothCnt;
  int pressCnt[KEY_NUM];
  int pressAt[KEY_NUM];
  int releaseCnt[KEY_NUM];
  int releaseAt[KEY_NUM];
  int longCnt[KEY_NUM];
  int longAt[KEY_NUM];
  int stateHighCnt[KEY_NUM];
  int stateLowCnt[KEY_NUM];
  int t0;
  int t1;
  logic [KEY_NUM-1:0] keys;

  key_debounce #(
    .CLK_FREQ     (10_000),
    .KEY_NUM      (KEY_NUM),
    .DEBOUNCE_MS  (2),
    .LONG_PRESS_MS(10)
  ) dut (
    .CLK_i        (CLK_i),
    .RST_i        (RST_i),
    .KEY_i        (KEY_i),
    .KEY_state_o  (KEY_state_o),
    .KEY_press_o  (KEY_press_o),
    .KEY_release_o(KEY_release_o),
    .KEY_long_o   (KEY_long_o)
  );

  // Free-running clock, period 10.
  initial begin
    CLK_i = 1'b0;
    forever #5 CLK_i = ~CLK_i;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCnt++;
    if (observed != expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [KEY_NUM-1:0] keyVal, input logic rstVal);
    KEY_i = keyVal;
    RST_i = rstVal;
  endtask

  task automatic clearLog();
    bothCnt = 0;
    for (int k = 0; k < KEY_NUM; k++) begin
      pressCnt[k]     = 0;
      pressAt[k]      = -1;
      releaseCnt[k]   = 0;
      releaseAt[k]    = -1;
      longCnt[k]      = 0;
      longAt[k]       = -1;
      stateHighCnt[k] = 0;
      stateLowCnt[k]  = 0;
    end
  endtask

  // Advances n cycles, sampling the outputs on each falling edge and logging
  // event counts and the cycle index at which each event was last seen.
  task automatic stepCycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK_i);
      cyc++;
      for (int k = 0; k < KEY_NUM; k++) begin
        if (KEY_press_o[k]) begin
          pressCnt[k]++;
          pressAt[k] = cyc;
        end
        if (KEY_release_o[k]) begin
          releaseCnt[k]++;
          releaseAt[k] = cyc;
        end
        if (KEY_long_o[k]) begin
          longCnt[k]++;
          longAt[k] = cyc;
        end
        if (KEY_state_o[k]) stateHighCnt[k]++;
        else stateLowCnt[k]++;
      end
      if ((KEY_press_o & KEY_release_o) != '0) bothCnt++;
    end
  endtask

  // Keys are driven right after a falling edge at cycle t; the next rising
  // edge is edge 0, so the pulse registered at edge 22 is sampled at t+23.
  initial begin
    errCnt   = 0;
    checkCnt = 0;
    cyc      = 0;
    clearLog();

    // 1: reset with all keys held, then a simultaneous press on all four
    keys = 4'b0000;
    applyStimulus(keys, 1'b1);
    stepCycle(3);
    checkOutput("rst_state", int'(KEY_state_o), 0);
    checkOutput("rst_events", int'({KEY_press_o, KEY_release_o, KEY_long_o}), 0);
    applyStimulus(keys, 1'b0);
    t0 = cyc;
    stepCycle(22);
    checkOutput("t1_press_early", int'(KEY_press_o), 0);
    stepCycle(1);
    checkOutput("t1_press_all", int'(KEY_press_o), 4'hF);
    checkOutput("t1_state_all", int'(KEY_state_o), 4'hF);
    stepCycle(1);
    checkOutput("t1_press_width", int'(KEY_press_o), 0);
    keys = 4'b1111;
    applyStimulus(keys, 1'b0);
    t1 = cyc;
    stepCycle(23);
    checkOutput("t1_release_all", int'(KEY_release_o), 4'hF);
    checkOutput("t1_state_drop", int'(KEY_state_o), 0);
    stepCycle(5);
    checkOutput("t1_no_long", longCnt[0] + longCnt[1] + longCnt[2] + longCnt[3], 0);

    // 2: clean press on key0, held 50 cycles
    clearLog();
    keys[0] = 1'b0;
    applyStimulus(keys, 1'b0);
    t0 = cyc;
    stepCycle(50);
    keys[0] = 1'b1;
    applyStimulus(keys, 1'b0);
    t1 = cyc;
    stepCycle(30);
    checkOutput("t2_press_cnt", pressCnt[0], 1);
    checkOutput("t2_press_lat", pressAt[0] - t0, 23);
    checkOutput("t2_release_cnt", releaseCnt[0], 1);
    checkOutput("t2_release_lat", releaseAt[0] - t1, 23);
    checkOutput("t2_state_cycles", stateHighCnt[0], 50);
    checkOutput("t2_long_cnt", longCnt[0], 0);
    checkOutput("t2_other_keys", pressCnt[1] + pressCnt[2] + pressCnt[3], 0);

    // 3: key1 bouncing every 5 cycles for 60 cycles, then left released
    clearLog();
    for (int j = 0; j < 12; j++) begin
      keys[1] = (j % 2 == 0) ? 1'b0 : 1'b1;
      applyStimulus(keys, 1'b0);
      stepCycle(5);
    end
    keys[1] = 1'b1;
    applyStimulus(keys, 1'b0);
    stepCycle(40);
    checkOutput("t3_press_cnt", pressCnt[1], 0);
    checkOutput("t3_state_high", stateHighCnt[1], 0);
    checkOutput("t3_release_cnt", releaseCnt[1], 0);

    // 4: long press on key2, held 200 cycles
    clearLog();
    keys[2] = 1'b0;
    applyStimulus(keys, 1'b0);
    t0 = cyc;
    stepCycle(200);
    keys[2] = 1'b1;
    applyStimulus(keys, 1'b0);
    t1 = cyc;
    stepCycle(30);
    checkOutput("t4_press_cnt", pressCnt[2], 1);
    checkOutput("t4_press_lat", pressAt[2] - t0, 23);
    checkOutput("t4_long_cnt", longCnt[2], 1);
    checkOutput("t4_long_lat", longAt[2] - pressAt[2], 99);
    checkOutput("t4_release_cnt", releaseCnt[2], 1);
    checkOutput("t4_release_lat", releaseAt[2] - t1, 23);

    // 5: key3 held with a 10-cycle release glitch in the middle
    clearLog();
    keys[3] = 1'b0;
    applyStimulus(keys, 1'b0);
    t0 = cyc;
    stepCycle(60);
    keys[3] = 1'b1;
    applyStimulus(keys, 1'b0);
    stepCycle(10);
    keys[3] = 1'b0;
    applyStimulus(keys, 1'b0);
    stepCycle(100);
    checkOutput("t5_press_cnt", pressCnt[3], 1);
    checkOutput("t5_glitch_release", releaseCnt[3], 0);
    checkOutput("t5_state_low", stateLowCnt[3], 22);
    checkOutput("t5_long_cnt", longCnt[3], 1);
    checkOutput("t5_long_lat", longAt[3] - t0, 122);
    keys[3] = 1'b1;
    applyStimulus(keys, 1'b0);
    stepCycle(30);
    checkOutput("t5_release_cnt", releaseCnt[3], 1);

    // 6: reset while key0 is held and accepted
    keys[0] = 1'b0;
    applyStimulus(keys, 1'b0);
    stepCycle(30);
    checkOutput("t6_state_before", int'(KEY_state_o[0]), 1);
    clearLog();
    #2;
    applyStimulus(keys, 1'b1);
    #1;
    checkOutput("t6_async_state", int'(KEY_state_o), 0);
    stepCycle(3);
    applyStimulus(keys, 1'b0);
    t1 = cyc;
    stepCycle(40);
    checkOutput("t6_no_release", releaseCnt[0], 0);
    checkOutput("t6_repress_cnt", pressCnt[0], 1);
    checkOutput("t6_repress_lat", pressAt[0] - t1, 23);
    keys[0] = 1'b1;
    applyStimulus(keys, 1'b0);
    stepCycle(30);
    checkOutput("t6_release_cnt", releaseCnt[0], 1);

    checkOutput("both_press_release", bothCnt, 0);

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
